// File: rtl/aes_stream_adapter_pkg.sv
// Shared types and constants for the AES stream adapter and the control FSM
// that consumes its completion flags.
package aes_stream_adapter_pkg;

   localparam int unsigned AES_WORD_W  = 32;
   localparam int unsigned AES_BLOCK_W = 128;
   localparam int unsigned AES_CNT_W   = 16;

   typedef enum logic [2:0] {
      IDLE,
      GATHER,
      OFFER,
      WAIT_RES,
      SCATTER,
      DONE
   } aes_adapt_state_t;

   // Completion flags as seen by the AES control FSM.
   typedef struct packed {
      logic                 done;
      logic [AES_CNT_W-1:0] blocks_done;
   } flags_engine_t;

endpackage

// File: rtl/aes_stream_adapter.sv
// Gathers DW-bit plaintext words into BW-bit blocks for the cipher core and
// serialises each ciphertext block back into DW-bit words, one block in flight.
module aes_stream_adapter
   import aes_stream_adapter_pkg::*;
#(
   parameter int unsigned DW    = AES_WORD_W,
   parameter int unsigned BW    = AES_BLOCK_W,
   parameter int unsigned CNT_W = AES_CNT_W
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clear,
   input  logic             enable,
   input  logic             start,
   input  logic [CNT_W-1:0] nblocks,
   input  logic             pt_valid,
   output logic             pt_ready,
   input  logic [DW-1:0]    pt_data,
   output logic             core_in_valid,
   input  logic             core_in_ready,
   output logic [BW-1:0]    core_in_data,
   input  logic             core_out_valid,
   output logic             core_out_ready,
   input  logic [BW-1:0]    core_out_data,
   output logic             ct_valid,
   input  logic             ct_ready,
   output logic [DW-1:0]    ct_data,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] blocks_done
);

   localparam int unsigned NWORDS = BW / DW;
   localparam int unsigned WCW    = (NWORDS > 1) ? $clog2(NWORDS) : 1;
   localparam logic [WCW-1:0] LAST_WORD = WCW'(NWORDS - 1);

   aes_adapt_state_t state, state_next;

   // Ascending packed range puts word 0 in the most significant slot.
   logic [0:NWORDS-1][DW-1:0] gather_buf;
   logic [0:NWORDS-1][DW-1:0] scatter_buf;

   logic [WCW-1:0]   word_cnt;
   logic [WCW-1:0]   word_next;
   logic [CNT_W-1:0] nblocks_q;
   logic [CNT_W-1:0] blocks_q;
   logic [CNT_W-1:0] blocks_inc;

   logic start_go;
   logic pt_fire;
   logic out_fire;
   logic ct_fire;
   logic last_word;
   logic last_block;

   assign last_word  = (word_cnt == LAST_WORD);
   assign word_next  = last_word ? '0 : word_cnt + WCW'(1);
   assign blocks_inc = blocks_q + CNT_W'(1);
   assign last_block = (blocks_inc == nblocks_q);

   assign start_go = (state == IDLE) & enable & start;
   assign pt_fire  = pt_ready & pt_valid;
   assign out_fire = core_out_ready & core_out_valid;
   assign ct_fire  = ct_valid & ct_ready;

   assign core_in_data = gather_buf;
   assign ct_data      = scatter_buf[word_cnt];
   assign blocks_done  = blocks_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else if (clear) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      if (enable) begin
         case (state)
            IDLE:     if (start) state_next = (nblocks == '0) ? DONE : GATHER;
            GATHER:   if (pt_valid && last_word) state_next = OFFER;
            OFFER:    if (core_in_ready) state_next = WAIT_RES;
            WAIT_RES: if (core_out_valid) state_next = SCATTER;
            SCATTER:  if (ct_ready && last_word) state_next = last_block ? DONE : GATHER;
            DONE:     state_next = IDLE;
            default:  state_next = IDLE;
         endcase
      end
   end

   always_comb begin
      pt_ready       = 1'b0;
      core_in_valid  = 1'b0;
      core_out_ready = 1'b0;
      ct_valid       = 1'b0;
      done           = 1'b0;
      busy           = (state != IDLE);
      case (state)
         GATHER:   pt_ready       = enable;
         OFFER:    core_in_valid  = enable;
         WAIT_RES: core_out_ready = enable;
         SCATTER:  ct_valid       = enable;
         DONE:     done           = enable;
         default:  ;
      endcase
   end

   // word_cnt is shared by gather and scatter; the two never overlap.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         gather_buf  <= '0;
         scatter_buf <= '0;
         word_cnt    <= '0;
         nblocks_q   <= '0;
         blocks_q    <= '0;
      end else if (clear) begin
         gather_buf  <= '0;
         scatter_buf <= '0;
         word_cnt    <= '0;
         nblocks_q   <= '0;
         blocks_q    <= '0;
      end else begin
         if (start_go) begin
            nblocks_q <= nblocks;
            blocks_q  <= '0;
            word_cnt  <= '0;
         end
         if (pt_fire) begin
            gather_buf[word_cnt] <= pt_data;
            word_cnt             <= word_next;
         end
         if (out_fire) begin
            scatter_buf <= core_out_data;
         end
         if (ct_fire) begin
            word_cnt <= word_next;
            if (last_word) begin
               blocks_q <= blocks_inc;
            end
         end
      end
   end

endmodule

// File: tb/tb_aes_stream_adapter.sv
// Randomised self-checking bench for aes_stream_adapter with a block-level
// reference model of the plaintext-to-ciphertext word stream.
module tb_aes_stream_adapter;

   localparam int DW    = 32;
   localparam int BW    = 128;
   localparam int CNT_W = 16;

   logic             clk = 1'b0;
   logic             reset, clear, enable, start;
   logic [CNT_W-1:0] nblocks;
   logic             pt_valid, pt_ready;
   logic [DW-1:0]    pt_data;
   logic             core_in_valid, core_in_ready;
   logic [BW-1:0]    core_in_data;
   logic             core_out_valid, core_out_ready;
   logic [BW-1:0]    core_out_data;
   logic             ct_valid, ct_ready;
   logic [DW-1:0]    ct_data;
   logic             busy, done;
   logic [CNT_W-1:0] blocks_done;

   aes_stream_adapter #(.DW(DW), .BW(BW), .CNT_W(CNT_W)) dut (
      .clk(clk), .reset(reset), .clear(clear), .enable(enable), .start(start),
      .nblocks(nblocks),
      .pt_valid(pt_valid), .pt_ready(pt_ready), .pt_data(pt_data),
      .core_in_valid(core_in_valid), .core_in_ready(core_in_ready), .core_in_data(core_in_data),
      .core_out_valid(core_out_valid), .core_out_ready(core_out_ready), .core_out_data(core_out_data),
      .ct_valid(ct_valid), .ct_ready(ct_ready), .ct_data(ct_data),
      .busy(busy), .done(done), .blocks_done(blocks_done)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // stimulus configuration
   logic [DW-1:0] pt_q[$];
   int            pt_gap, ct_gap, core_gap, core_lat;
   bit            fixed_mode;
   logic [BW-1:0] fixed_resp;
   bit            stop;
   bit            timed_out;
   int            start_cyc;

   // observations
   logic [DW-1:0] ct_obs[$];
   logic [BW-1:0] blk_obs[$];
   int            done_cnt, done_cyc, first_pt_cyc, pt_hs;
   int            stab_err, stall_err, act_pt, act_in, act_ct;

   // reference model outputs
   logic [DW-1:0] exp_ct[$];
   logic [BW-1:0] exp_blk[$];

   function automatic logic [BW-1:0] xform(input logic [BW-1:0] b);
      return {b[95:0], b[127:96]} ^ 128'h0F1E2D3C_4B5A6978_8796A5B4_C3D2E1F0;
   endfunction

   function automatic void build_model(input int nb);
      logic [BW-1:0] blk, resp;
      exp_ct.delete();
      exp_blk.delete();
      for (int k = 0; k < nb; k++) begin
         blk = {pt_q[4*k], pt_q[4*k+1], pt_q[4*k+2], pt_q[4*k+3]};
         exp_blk.push_back(blk);
         resp = fixed_mode ? fixed_resp : xform(blk);
         for (int j = 0; j < 4; j++) exp_ct.push_back(resp[BW-1-32*j -: 32]);
      end
   endfunction

   // Monitor: samples settled values just after each falling edge.
   bit            ct_hold, in_hold;
   logic [DW-1:0] ct_prev;
   logic [BW-1:0] in_prev;
   always begin
      @(negedge clk);
      #1;
      if (ct_valid && ct_ready) ct_obs.push_back(ct_data);
      if (core_in_valid && core_in_ready) blk_obs.push_back(core_in_data);
      if (done) begin done_cnt++; done_cyc = cyc; end
      if (pt_ready) act_pt++;
      if (core_in_valid) act_in++;
      if (ct_valid) act_ct++;
      if (!enable && (pt_ready || core_in_valid || core_out_ready || ct_valid)) stall_err++;
      if (reset || clear) begin
         ct_hold = 0;
         in_hold = 0;
      end else if (enable) begin
         if (ct_hold && !(ct_valid && ct_data === ct_prev)) stab_err++;
         if (in_hold && !(core_in_valid && core_in_data === in_prev)) stab_err++;
         ct_hold = ct_valid && !ct_ready;
         ct_prev = ct_data;
         in_hold = core_in_valid && !core_in_ready;
         in_prev = core_in_data;
      end
   end

   task automatic drive_pt();
      int idx = 0;
      bit fired = 0;
      while (!stop) begin
         @(negedge clk);
         if (fired) begin pt_valid = 0; fired = 0; end
         if (!pt_valid && idx < pt_q.size() && $urandom_range(99) >= pt_gap) begin
            pt_valid = 1;
            pt_data  = pt_q[idx];
         end
         #1;
         if (pt_valid && pt_ready) begin
            if (first_pt_cyc < 0) first_pt_cyc = cyc;
            pt_hs++;
            idx++;
            fired = 1;
         end
      end
      pt_valid = 0;
   endtask

   task automatic drive_core();
      logic [BW-1:0] resp;
      while (!stop) begin
         @(negedge clk);
         core_in_ready = ($urandom_range(99) >= core_gap);
         #1;
         if (core_in_valid && core_in_ready) begin
            resp = fixed_mode ? fixed_resp : xform(core_in_data);
            @(negedge clk);
            core_in_ready = 0;
            for (int i = 0; i < core_lat; i++) @(negedge clk);
            core_out_valid = 1;
            core_out_data  = resp;
            #1;
            while (!stop && !core_out_ready) begin @(negedge clk); #1; end
            @(negedge clk);
            core_out_valid = 0;
         end
      end
      core_in_ready  = 0;
      core_out_valid = 0;
   endtask

   task automatic drive_ct();
      while (!stop) begin
         @(negedge clk);
         ct_ready = ($urandom_range(99) >= ct_gap);
      end
      ct_ready = 0;
   endtask

   task automatic run_job(input logic [CNT_W-1:0] nb);
      timed_out = 0;
      stop      = 0;
      ct_obs.delete();
      blk_obs.delete();
      done_cnt = 0; done_cyc = -1; first_pt_cyc = -1; pt_hs = 0;
      stab_err = 0; stall_err = 0; act_pt = 0; act_in = 0; act_ct = 0;
      @(negedge clk);
      nblocks   = nb;
      start     = 1;
      start_cyc = cyc;
      @(negedge clk);
      start = 0;
      fork
         drive_pt();
         drive_core();
         drive_ct();
         begin
            int n    = 0;
            int tail = -1;
            while (!stop) begin
               @(negedge clk);
               n++;
               if (done_cnt > 0 && tail < 0) tail = 3;
               if (tail > 0) begin tail--; if (tail == 0) stop = 1; end
               if (n > 3000) begin timed_out = 1; stop = 1; end
            end
         end
      join
      pt_valid = 0; core_in_ready = 0; core_out_valid = 0; ct_ready = 0;
   endtask

   task automatic fill_random(input int nwords);
      pt_q.delete();
      for (int i = 0; i < nwords; i++) pt_q.push_back($urandom);
   endtask

   task automatic check_stream(input string tag);
      logic [DW-1:0] got_w;
      logic [BW-1:0] got_b;
      n_tests++;
      if (blk_obs.size() !== exp_blk.size()) begin
         n_fail++;
         $display("FAIL %s_blk_count: got %0d expected %0d", tag, blk_obs.size(), exp_blk.size());
      end
      for (int i = 0; i < exp_blk.size(); i++) begin
         got_b = (i < blk_obs.size()) ? blk_obs[i] : 'x;
         n_tests++;
         if (got_b !== exp_blk[i]) begin
            n_fail++;
            $display("FAIL %s_blk[%0d]: got %h expected %h", tag, i, got_b, exp_blk[i]);
         end
      end
      n_tests++;
      if (ct_obs.size() !== exp_ct.size()) begin
         n_fail++;
         $display("FAIL %s_ct_count: got %0d expected %0d", tag, ct_obs.size(), exp_ct.size());
      end
      for (int i = 0; i < exp_ct.size(); i++) begin
         got_w = (i < ct_obs.size()) ? ct_obs[i] : 'x;
         n_tests++;
         if (got_w !== exp_ct[i]) begin
            n_fail++;
            $display("FAIL %s_ct[%0d]: got %h expected %h", tag, i, got_w, exp_ct[i]);
         end
      end
   endtask

   task automatic test_reset();
      reset = 1; clear = 0; enable = 1; start = 0; nblocks = '0;
      pt_valid = 0; pt_data = '0; core_in_ready = 0; core_out_valid = 0;
      core_out_data = '0; ct_ready = 0;
      repeat (3) @(negedge clk);
      #1;
      n_tests++;
      if ({pt_ready, core_in_valid, core_in_data, core_out_ready, ct_valid, ct_data,
           busy, done, blocks_done} !== '0) begin
         n_fail++;
         $display("FAIL reset_outputs: got busy=%b done=%b blocks_done=%0d in_data=%h ct_data=%h, expected all zero",
                  busy, done, blocks_done, core_in_data, ct_data);
      end
      @(negedge clk);
      reset = 0;
      @(negedge clk);
      #1;
      n_tests++;
      if (busy !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_busy_after_release: got %b expected 0", busy);
      end
   endtask

   task automatic test_single_block();
      pt_q = '{32'h00112233, 32'h44556677, 32'h8899AABB, 32'hCCDDEEFF};
      fixed_mode = 1;
      fixed_resp = 128'h69C4E0D8_6A7B0430_D8CDB780_70B4C55A;
      pt_gap = 0; ct_gap = 0; core_gap = 0; core_lat = 0;
      exp_blk = '{128'h00112233_44556677_8899AABB_CCDDEEFF};
      exp_ct  = '{32'h69C4E0D8, 32'h6A7B0430, 32'hD8CDB780, 32'h70B4C55A};
      run_job(1);
      n_tests++;
      if (timed_out !== 1'b0) begin n_fail++; $display("FAIL single_timeout: got 1 expected 0"); end
      check_stream("single");
      n_tests++;
      if (done_cnt !== 1) begin n_fail++; $display("FAIL single_done_pulses: got %0d expected 1", done_cnt); end
      n_tests++;
      if (done_cyc - first_pt_cyc !== 10) begin
         n_fail++;
         $display("FAIL single_latency: got %0d expected 10", done_cyc - first_pt_cyc);
      end
      n_tests++;
      if (blocks_done !== 16'd1) begin n_fail++; $display("FAIL single_blocks_done: got %0d expected 1", blocks_done); end
      n_tests++;
      if (busy !== 1'b0) begin n_fail++; $display("FAIL single_busy_after: got %b expected 0", busy); end
   endtask

   task automatic test_multi_random();
      fixed_mode = 0;
      fill_random(12);
      pt_gap = 40; ct_gap = 40; core_gap = 30; core_lat = $urandom_range(3, 0);
      build_model(3);
      run_job(3);
      n_tests++;
      if (timed_out !== 1'b0) begin n_fail++; $display("FAIL multi_timeout: got 1 expected 0"); end
      check_stream("multi");
      n_tests++;
      if (stab_err !== 0) begin n_fail++; $display("FAIL multi_stability: got %0d violations expected 0", stab_err); end
      n_tests++;
      if (blocks_done !== 16'd3) begin n_fail++; $display("FAIL multi_blocks_done: got %0d expected 3", blocks_done); end
      n_tests++;
      if (done_cnt !== 1) begin n_fail++; $display("FAIL multi_done_pulses: got %0d expected 1", done_cnt); end
   endtask

   task automatic test_zero_blocks();
      pt_q.delete();
      pt_gap = 0; ct_gap = 0; core_gap = 0; core_lat = 0;
      run_job(0);
      n_tests++;
      if (timed_out !== 1'b0) begin n_fail++; $display("FAIL zero_timeout: got 1 expected 0"); end
      n_tests++;
      if (done_cnt !== 1) begin n_fail++; $display("FAIL zero_done_pulses: got %0d expected 1", done_cnt); end
      n_tests++;
      if (done_cyc !== start_cyc + 1) begin
         n_fail++;
         $display("FAIL zero_done_timing: got cycle %0d expected %0d", done_cyc, start_cyc + 1);
      end
      n_tests++;
      if (act_pt + act_in + act_ct !== 0) begin
         n_fail++;
         $display("FAIL zero_activity: got pt=%0d in=%0d ct=%0d expected none", act_pt, act_in, act_ct);
      end
      n_tests++;
      if (blocks_done !== 16'd0) begin n_fail++; $display("FAIL zero_blocks_done: got %0d expected 0", blocks_done); end
   endtask

   task automatic test_stall();
      bit found;
      fixed_mode = 0;
      fill_random(4);
      pt_gap = 0; ct_gap = 0; core_gap = 0; core_lat = 0;
      build_model(1);
      fork
         run_job(1);
         begin
            found = 0;
            for (int n = 0; n < 200 && !found; n++) begin
               @(negedge clk);
               if (pt_hs >= 2) found = 1;
            end
            if (found) begin
               enable = 0;
               repeat (5) @(negedge clk);
               enable = 1;
            end
            n_tests++;
            if (!found) begin n_fail++; $display("FAIL stall_gather_wait: got no 2nd word expected 2 words accepted"); end
            found = 0;
            for (int n = 0; n < 200 && !found; n++) begin
               @(negedge clk);
               if (ct_obs.size() >= 1) found = 1;
            end
            if (found) begin
               enable = 0;
               repeat (5) @(negedge clk);
               enable = 1;
            end
            n_tests++;
            if (!found) begin n_fail++; $display("FAIL stall_scatter_wait: got no ct word expected 1 word"); end
         end
      join
      enable = 1;
      n_tests++;
      if (timed_out !== 1'b0) begin n_fail++; $display("FAIL stall_timeout: got 1 expected 0"); end
      check_stream("stall");
      n_tests++;
      if (stall_err !== 0) begin n_fail++; $display("FAIL stall_suppress: got %0d active handshakes expected 0", stall_err); end
      n_tests++;
      if (done_cnt !== 1) begin n_fail++; $display("FAIL stall_done_pulses: got %0d expected 1", done_cnt); end
   endtask

   task automatic test_restart();
      bit found;
      fixed_mode = 0;
      fill_random(8);
      pt_gap = 20; ct_gap = 20; core_gap = 20; core_lat = 1;
      build_model(2);
      fork
         run_job(2);
         begin
            found = 0;
            for (int n = 0; n < 300 && !found; n++) begin
               @(negedge clk);
               if (pt_hs >= 1) found = 1;
            end
            nblocks = 16'd7; start = 1;
            @(negedge clk);
            start = 0;
            for (int n = 0; n < 300 && ct_obs.size() < 1; n++) @(negedge clk);
            nblocks = 16'd9; start = 1;
            @(negedge clk);
            start = 0;
         end
      join
      n_tests++;
      if (timed_out !== 1'b0) begin n_fail++; $display("FAIL restart_timeout: got 1 expected 0"); end
      check_stream("restart");
      n_tests++;
      if (blocks_done !== 16'd2) begin n_fail++; $display("FAIL restart_blocks_done: got %0d expected 2", blocks_done); end
      n_tests++;
      if (done_cnt !== 1) begin n_fail++; $display("FAIL restart_done_pulses: got %0d expected 1", done_cnt); end
   endtask

   task automatic test_clear_reset();
      bit found;
      fixed_mode = 0;
      fill_random(8);
      pt_gap = 0; ct_gap = 0; core_gap = 0; core_lat = 4;
      fork
         run_job(2);
         begin
            found = 0;
            for (int n = 0; n < 300 && !found; n++) begin
               @(negedge clk);
               #2;
               if (core_out_ready) found = 1;
            end
            if (found) begin
               clear = 1;
               @(negedge clk);
               #2;
               n_tests++;
               if ({pt_ready, core_in_valid, core_in_data, core_out_ready, ct_valid, ct_data,
                    busy, done, blocks_done} !== '0) begin
                  n_fail++;
                  $display("FAIL clear_outputs: got busy=%b in_data=%h ct_data=%h expected all zero",
                           busy, core_in_data, ct_data);
               end
               clear = 0;
            end else begin
               n_tests++; n_fail++;
               $display("FAIL clear_wait_res: got no WAIT_RES expected core_out_ready");
            end
            stop = 1;
         end
      join
      fill_random(4);
      core_lat = 0;
      fork
         run_job(1);
         begin
            found = 0;
            for (int n = 0; n < 300 && !found; n++) begin
               @(negedge clk);
               #2;
               if (ct_valid) found = 1;
            end
            if (found) begin
               reset = 1;
               #1;
               n_tests++;
               if ({pt_ready, core_in_valid, core_in_data, core_out_ready, ct_valid, ct_data,
                    busy, done, blocks_done} !== '0) begin
                  n_fail++;
                  $display("FAIL async_reset_outputs: got busy=%b ct_valid=%b ct_data=%h expected all zero",
                           busy, ct_valid, ct_data);
               end
            end else begin
               n_tests++; n_fail++;
               $display("FAIL reset_scatter_wait: got no SCATTER expected ct_valid");
            end
            stop = 1;
            repeat (2) @(negedge clk);
            reset = 0;
         end
      join
      reset = 0;
      fill_random(4);
      build_model(1);
      run_job(1);
      n_tests++;
      if (timed_out !== 1'b0) begin n_fail++; $display("FAIL fresh_timeout: got 1 expected 0"); end
      check_stream("fresh");
      n_tests++;
      if (blocks_done !== 16'd1) begin n_fail++; $display("FAIL fresh_blocks_done: got %0d expected 1", blocks_done); end
      n_tests++;
      if (done_cnt !== 1) begin n_fail++; $display("FAIL fresh_done_pulses: got %0d expected 1", done_cnt); end
   endtask

   initial begin
      #800000;
      $display("FAIL watchdog: simulation time bound exceeded");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_single_block();
      test_multi_random();
      test_zero_blocks();
      test_stall();
      test_restart();
      test_clear_reset();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
